mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Memory-access sequencer in the MEM stage, directly downstream of the store-data packager.
- Consumes the packaged (lane-replicated) store data, the effective address and the mem_op code.
- Generates the byte write mask and runs a valid/ready request plus response handshake to the data memory, stalling the pipeline until the access completes.
- Returns the raw 64-bit load word, to be truncated and sign-extended by a later stage.

Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted with bus_err.
- ALIGN_CHECK, 1, when 1, misaligned H/W/D accesses are rejected; when 0, they are issued unchanged.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM-stage instruction performs a memory access; held stable while stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  64  effective byte address (addr_t)
- cpu_wdata  in  64  packaged store data (data_t)
- cpu_mem_op  in  3  CorePack::mem_op_enum
- stall  out  1  freeze the pipeline upstream of MEM
- cpu_done  out  1  one-cycle pulse: access finished
- cpu_rdata  out  64  raw 8-byte-aligned load word; valid when cpu_done=1 and the access is a load
- misalign_err  out  1  one-cycle pulse: access rejected
- bus_err  out  1  one-cycle pulse: access timed out
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_we  out  1  write enable
- mem_addr  out  64  {addr[63:3],3'b000}
- mem_wdata  out  64  registered packaged data
- mem_wmask  out  8  byte enables (mask_t)
- mem_resp_valid  in  1  response or write acknowledgement
- mem_resp_rdata  in  64  read data

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, timeout counter=0, all captured registers=0, every output=0.
- Mask from addr[2:0]:
  - MEM_B/UB: 8'h01<<a
  - MEM_H/UH: 8'h03<<{a[2:1],1'b0}
  - MEM_W/UW: 8'h0F<<{a[2],2'b00}
  - MEM_D: 8'hFF
  - MEM_NO: 8'h00
- Misaligned conditions: H/UH with a[0]=1; W/UW with a[1:0]!=0; D with a[2:0]!=0.
- A request is "legal" when cpu_req=1, mem_op!=MEM_NO, and it is not misaligned.
- A request is "bad" when cpu_req=1, mem_op!=MEM_NO, it is misaligned, and ALIGN_CHECK=1.
- cpu_req=1 with MEM_NO is a no-op: no stall, no pulse.
- FSM states are IDLE, REQ, WAIT, DONE. Transitions:
  - IDLE, legal request: capture we, aligned addr, wdata, mask and op; go to REQ.
  - IDLE, bad request: misalign_err=1 for exactly one cycle; stay in IDLE; no memory traffic.
  - REQ: mem_req_valid=1, driven from registers only. Request fields stay stable until mem_req_ready. On mem_req_ready go to WAIT.
  - WAIT: on mem_resp_valid, capture mem_resp_rdata (loads only; stores keep the old cpu_rdata) and go to DONE. mem_resp_valid in the same cycle as acceptance is ignored; responses are earliest one cycle after acceptance.
  - DONE: cpu_done=1; go to IDLE. A cpu_req seen in DONE is not re-issued, because it is the same instruction whose stall has just dropped.
- stall (combinational) = (IDLE & legal) | REQ | WAIT. stall=0 in DONE and on a misalign cycle.
- Minimum latency is 3 cycles: the IDLE capture, then REQ with ready=1, then WAIT with the response, giving cpu_done in the 4th cycle.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT: bus_err=1 for one cycle, mem_req_valid drops, go to IDLE, and stall=0 that same cycle.
  - A late mem_resp_valid in IDLE is ignored.
- mem_we, mem_wmask and mem_wdata are meaningful only while mem_req_valid=1.

Decomposition:
- CorePack supplies data_t, addr_t, mask_t (logic [7:0]) and mem_op_enum.
- Add mem_fsm_e {IDLE, REQ, WAIT, DONE} to CorePack for waveform and debug visibility.
- One combinational sub-module, mem_mask_gen (addr[2:0], mem_op -> mask, misaligned), which the load-truncation stage reuses.

Test Plan:
- Store MEM_W at addr 0x1004, wdata 0xDEADBEEF_DEADBEEF, ready=1 immediately, response after 1 cycle -> mem_addr=0x1000, mem_wmask=8'hF0, mem_we=1, stall high for 3 cycles, cpu_done pulse in cycle 4.
- Load MEM_B at 0x2007, ready delayed 5 cycles, response 0x1122334455667788 -> mem_req_valid and request fields stable all 5 cycles, mask=8'h80, cpu_rdata=0x1122334455667788 with cpu_done.
- MEM_H at 0x3001 with ALIGN_CHECK=1 -> misalign_err one pulse, mem_req_valid never asserts, stall=0.
- Ready held 0 forever with TIMEOUT=8 -> bus_err pulse exactly 8 cycles after REQ entry, FSM returns to IDLE, stall drops.
- rstn asserted while in WAIT, then released -> all outputs 0 immediately, FSM in IDLE, a subsequent MEM_D load at 0x4000 completes with mask 8'hFF.
- Back-to-back stores MEM_B at 0x10 then MEM_D at 0x18 -> exactly two memory requests, no duplicate issue while in DONE, masks 8'h01 then 8'hFF.

Source files
------------

// File: rtl/CorePack.sv
// Shared core types for the MEM stage: data/address/mask widths, the
// memory-operation code and the memory sequencer state encoding.
package CorePack;

   typedef logic [63:0] data_t;
   typedef logic [63:0] addr_t;
   typedef logic [7:0]  mask_t;

   // Memory operation carried by the MEM-stage instruction.
   typedef enum logic [2:0] {
      MEM_NO = 3'd0,
      MEM_B  = 3'd1,
      MEM_H  = 3'd2,
      MEM_W  = 3'd3,
      MEM_D  = 3'd4,
      MEM_UB = 3'd5,
      MEM_UH = 3'd6,
      MEM_UW = 3'd7
   } mem_op_enum;

   // Memory request sequencer states, kept here so debug views share names.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mem_fsm_e;

endpackage

// File: rtl/mem_mask_gen.sv
// Byte-enable and alignment decode for a memory access. Purely
// combinational; also reused by the load-truncation stage.
module mem_mask_gen
   import CorePack::*;
(
   input  logic [2:0] addr_lo_i,
   input  mem_op_enum mem_op_i,
   output mask_t      mask_o,
   output logic       misaligned_o
);

   // Mask is shifted to the addressed lane; misalignment flags sub-size offsets.
   always_comb begin
      mask_o       = 8'h00;
      misaligned_o = 1'b0;
      case (mem_op_i)
         MEM_B, MEM_UB: begin
            mask_o = 8'h01 << addr_lo_i;
         end
         MEM_H, MEM_UH: begin
            mask_o       = 8'h03 << {addr_lo_i[2:1], 1'b0};
            misaligned_o = addr_lo_i[0];
         end
         MEM_W, MEM_UW: begin
            mask_o       = 8'h0F << {addr_lo_i[2], 2'b00};
            misaligned_o = |addr_lo_i[1:0];
         end
         MEM_D: begin
            mask_o       = 8'hFF;
            misaligned_o = |addr_lo_i;
         end
         default: begin
            mask_o       = 8'h00;
            misaligned_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage memory access sequencer. Captures one access from the pipeline,
// presents it on a valid/ready request channel, waits for the response and
// pulses cpu_done. Stalls the pipeline for the duration and aborts with
// bus_err if the access takes TIMEOUT cycles in REQ+WAIT.
module mem_req_ctrl
   import CorePack::*;
#(
   parameter int unsigned TIMEOUT     = 255,
   parameter bit          ALIGN_CHECK = 1'b1
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  addr_t      cpu_addr,
   input  data_t      cpu_wdata,
   input  mem_op_enum cpu_mem_op,
   output logic       stall,
   output logic       cpu_done,
   output data_t      cpu_rdata,
   output logic       misalign_err,
   output logic       bus_err,
   output logic       mem_req_valid,
   input  logic       mem_req_ready,
   output logic       mem_we,
   output addr_t      mem_addr,
   output data_t      mem_wdata,
   output mask_t      mem_wmask,
   input  logic       mem_resp_valid,
   input  data_t      mem_resp_rdata
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

   mem_fsm_e         state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   addr_t            addr_q;
   data_t            wdata_q;
   mask_t            mask_q;
   data_t            rdata_q;

   mask_t            mask;
   logic             misaligned;
   logic             op_active;
   logic             legal;
   logic             bad;
   logic             busy;
   logic             tmo;

   mem_mask_gen u_mask_gen (
      .addr_lo_i    (cpu_addr[2:0]),
      .mem_op_i     (cpu_mem_op),
      .mask_o       (mask),
      .misaligned_o (misaligned)
   );

   assign op_active = cpu_req && (cpu_mem_op != MEM_NO);
   assign legal     = op_active && (!misaligned || !ALIGN_CHECK);
   assign bad       = op_active && misaligned && ALIGN_CHECK;
   assign busy      = (state_q == REQ) || (state_q == WAIT);
   // The timeout cycle itself is the abort cycle: no request, no stall.
   assign tmo       = busy && (cnt_q == TMO_VAL);

   // Sequencer: capture in IDLE, hold request in REQ, collect response in WAIT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (legal) begin
                  we_q    <= cpu_we;
                  addr_q  <= {cpu_addr[63:3], 3'b000};
                  wdata_q <= cpu_wdata;
                  mask_q  <= mask;
                  cnt_q   <= '0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (tmo) begin
                  state_q <= IDLE;
               end else if (mem_req_ready) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (tmo) begin
                  state_q <= IDLE;
               end else if (mem_resp_valid) begin
                  if (!we_q) begin
                     rdata_q <= mem_resp_rdata;
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               // The instruction still on cpu_req here is the one just served.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Reset gating keeps the input-dependent IDLE decodes quiet during reset.
   assign stall         = (rstn && (state_q == IDLE) && legal) || (busy && !tmo);
   assign misalign_err  = rstn && (state_q == IDLE) && bad;
   assign mem_req_valid = (state_q == REQ) && !tmo;
   assign bus_err       = tmo;
   assign cpu_done      = (state_q == DONE);
   assign cpu_rdata     = rdata_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = mask_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with hand-computed expectations.
module tb_mem_req_ctrl;
   import CorePack::*;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cpu_req, cpu_we;
   addr_t      cpu_addr;
   data_t      cpu_wdata;
   mem_op_enum cpu_mem_op;
   logic       stall, cpu_done, misalign_err, bus_err;
   data_t      cpu_rdata;
   logic       mem_req_valid, mem_req_ready, mem_we;
   addr_t      mem_addr;
   data_t      mem_wdata;
   mask_t      mem_wmask;
   logic       mem_resp_valid;
   data_t      mem_resp_rdata;

   int n_total = 0;
   int n_bad   = 0;
   int n_acc   = 0;
   int acc0;

   mem_req_ctrl #(.TIMEOUT(8), .ALIGN_CHECK(1'b1)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_mem_op     (cpu_mem_op),
      .stall          (stall),
      .cpu_done       (cpu_done),
      .cpu_rdata      (cpu_rdata),
      .misalign_err   (misalign_err),
      .bus_err        (bus_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   always #5 clk = ~clk;

   // Count accepted requests on the memory side.
   always @(posedge clk) begin
      if (mem_req_valid && mem_req_ready) n_acc <= n_acc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   task automatic drive(input logic we, input addr_t a, input data_t d, input mem_op_enum op);
      cpu_req    = 1'b1;
      cpu_we     = we;
      cpu_addr   = a;
      cpu_wdata  = d;
      cpu_mem_op = op;
   endtask

   task automatic idle();
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      cpu_mem_op = MEM_NO;
   endtask

   initial begin
      rstn           = 1'b0;
      idle();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;

      // Reset with a legal request presented: everything must stay at zero
      #1;
      drive(1'b0, 64'h0, 64'h0, MEM_D);
      look();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_done", 64'(cpu_done), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_rdata", 64'(cpu_rdata), 64'd0);
      repeat (2) @(posedge clk);
      cyc();
      idle();
      rstn = 1'b1;

      // T1: store W at 0x1004, immediate ready, response one cycle later
      cyc(); drive(1'b1, 64'h1004, 64'hDEADBEEF_DEADBEEF, MEM_W); mem_req_ready = 1'b1; look();
      chk("t1_cap_stall", 64'(stall), 64'd1);
      chk("t1_cap_valid", 64'(mem_req_valid), 64'd0);
      cyc(); look();
      chk("t1_req_valid", 64'(mem_req_valid), 64'd1);
      chk("t1_addr", 64'(mem_addr), 64'h1000);
      chk("t1_mask", 64'(mem_wmask), 64'hF0);
      chk("t1_we", 64'(mem_we), 64'd1);
      chk("t1_wdata", 64'(mem_wdata), 64'hDEADBEEF_DEADBEEF);
      chk("t1_req_stall", 64'(stall), 64'd1);
      cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hAAAA_5555_AAAA_5555; look();
      chk("t1_wait_stall", 64'(stall), 64'd1);
      chk("t1_wait_valid", 64'(mem_req_valid), 64'd0);
      chk("t1_wait_done", 64'(cpu_done), 64'd0);
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t1_done", 64'(cpu_done), 64'd1);
      chk("t1_done_stall", 64'(stall), 64'd0);
      chk("t1_store_rdata", 64'(cpu_rdata), 64'd0);
      cyc(); idle(); look();
      chk("t1_done_clr", 64'(cpu_done), 64'd0);

      // T2: load B at 0x2007, ready held low for 5 REQ cycles
      cyc(); drive(1'b0, 64'h2007, 64'h0, MEM_B); look();
      chk("t2_cap_stall", 64'(stall), 64'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(); look();
         chk("t2_hold_valid", 64'(mem_req_valid), 64'd1);
         chk("t2_hold_addr", 64'(mem_addr), 64'h2000);
         chk("t2_hold_mask", 64'(mem_wmask), 64'h80);
         chk("t2_hold_we", 64'(mem_we), 64'd0);
         chk("t2_hold_stall", 64'(stall), 64'd1);
      end
      // Accept; a response in the acceptance cycle must be ignored
      cyc(); mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_0000_FFFF_0000; look();
      chk("t2_acc_valid", 64'(mem_req_valid), 64'd1);
      cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b0; look();
      chk("t2_wait_stall", 64'(stall), 64'd1);
      chk("t2_wait_done", 64'(cpu_done), 64'd0);
      cyc(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1122334455667788; look();
      chk("t2_resp_stall", 64'(stall), 64'd1);
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t2_done", 64'(cpu_done), 64'd1);
      chk("t2_rdata", 64'(cpu_rdata), 64'h1122334455667788);
      cyc(); idle(); look();

      // T3: misaligned H at 0x3001 is rejected without memory traffic
      cyc(); drive(1'b0, 64'h3001, 64'h0, MEM_H); look();
      chk("t3_mis_err", 64'(misalign_err), 64'd1);
      chk("t3_mis_stall", 64'(stall), 64'd0);
      chk("t3_mis_valid", 64'(mem_req_valid), 64'd0);
      cyc(); idle(); look();
      chk("t3_err_clr", 64'(misalign_err), 64'd0);
      chk("t3_no_req", 64'(mem_req_valid), 64'd0);
      // Misaligned W at 0x3002 also rejected
      cyc(); drive(1'b1, 64'h3002, 64'h0, MEM_W); look();
      chk("t3_misw_err", 64'(misalign_err), 64'd1);
      // MEM_NO is a no-op
      cyc(); drive(1'b1, 64'h3000, 64'h0, MEM_NO); look();
      chk("t3_nop_stall", 64'(stall), 64'd0);
      chk("t3_nop_err", 64'(misalign_err), 64'd0);
      cyc(); idle(); look();
      chk("t3_nop_valid", 64'(mem_req_valid), 64'd0);

      // T4: ready never arrives -> bus_err 8 cycles after REQ entry
      cyc(); drive(1'b0, 64'h5000, 64'h0, MEM_W); mem_req_ready = 1'b0; look();
      chk("t4_cap_stall", 64'(stall), 64'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(); look();
         chk("t4_req_valid", 64'(mem_req_valid), 64'd1);
         chk("t4_no_err", 64'(bus_err), 64'd0);
         chk("t4_stall", 64'(stall), 64'd1);
      end
      chk("t4_mask", 64'(mem_wmask), 64'h0F);
      cyc(); look();
      chk("t4_bus_err", 64'(bus_err), 64'd1);
      chk("t4_err_valid", 64'(mem_req_valid), 64'd0);
      chk("t4_err_stall", 64'(stall), 64'd0);
      // Late response while idle must be ignored
      cyc(); idle(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0; look();
      chk("t4_err_clr", 64'(bus_err), 64'd0);
      chk("t4_idle_stall", 64'(stall), 64'd0);
      chk("t4_idle_valid", 64'(mem_req_valid), 64'd0);
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t4_late_done", 64'(cpu_done), 64'd0);
      chk("t4_late_rdata", 64'(cpu_rdata), 64'h1122334455667788);

      // T5: reset asserted while in WAIT, then a D load at 0x4000
      cyc(); drive(1'b1, 64'h6002, 64'h0123456789ABCDEF, MEM_H); mem_req_ready = 1'b1; look();
      cyc(); look();
      chk("t5_req_mask", 64'(mem_wmask), 64'h0C);
      cyc(); mem_req_ready = 1'b0; look();
      chk("t5_wait_stall", 64'(stall), 64'd1);
      rstn = 1'b0;
      #1;
      chk("t5_rst_stall", 64'(stall), 64'd0);
      chk("t5_rst_valid", 64'(mem_req_valid), 64'd0);
      chk("t5_rst_we", 64'(mem_we), 64'd0);
      chk("t5_rst_addr", 64'(mem_addr), 64'd0);
      chk("t5_rst_wdata", 64'(mem_wdata), 64'd0);
      chk("t5_rst_mask", 64'(mem_wmask), 64'd0);
      chk("t5_rst_rdata", 64'(cpu_rdata), 64'd0);
      chk("t5_rst_done", 64'(cpu_done), 64'd0);
      chk("t5_rst_bus", 64'(bus_err), 64'd0);
      chk("t5_rst_mis", 64'(misalign_err), 64'd0);
      cyc(); rstn = 1'b1; idle(); look();
      chk("t5_post_valid", 64'(mem_req_valid), 64'd0);
      chk("t5_post_stall", 64'(stall), 64'd0);
      cyc(); drive(1'b0, 64'h4000, 64'h0, MEM_D); mem_req_ready = 1'b1; look();
      chk("t5_d_cap", 64'(stall), 64'd1);
      cyc(); look();
      chk("t5_d_valid", 64'(mem_req_valid), 64'd1);
      chk("t5_d_mask", 64'(mem_wmask), 64'hFF);
      chk("t5_d_addr", 64'(mem_addr), 64'h4000);
      chk("t5_d_we", 64'(mem_we), 64'd0);
      cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFEF00D_12345678; look();
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t5_d_done", 64'(cpu_done), 64'd1);
      chk("t5_d_rdata", 64'(cpu_rdata), 64'hCAFEF00D_12345678);
      cyc(); idle(); look();

      // T6: back-to-back stores, no re-issue while in DONE
      acc0 = n_acc;
      cyc(); drive(1'b1, 64'h10, 64'h5A5A_5A5A_5A5A_5A5A, MEM_B); mem_req_ready = 1'b1; look();
      cyc(); look();
      chk("t6_b_mask", 64'(mem_wmask), 64'h01);
      chk("t6_b_addr", 64'(mem_addr), 64'h10);
      cyc(); mem_resp_valid = 1'b1; look();
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t6_b_done", 64'(cpu_done), 64'd1);
      chk("t6_b_done_valid", 64'(mem_req_valid), 64'd0);
      chk("t6_b_done_stall", 64'(stall), 64'd0);
      cyc(); drive(1'b1, 64'h18, 64'h0102030405060708, MEM_D); look();
      chk("t6_d_cap_valid", 64'(mem_req_valid), 64'd0);
      chk("t6_d_cap_stall", 64'(stall), 64'd1);
      cyc(); look();
      chk("t6_d_valid", 64'(mem_req_valid), 64'd1);
      chk("t6_d_mask", 64'(mem_wmask), 64'hFF);
      chk("t6_d_addr", 64'(mem_addr), 64'h18);
      chk("t6_d_wdata", 64'(mem_wdata), 64'h0102030405060708);
      cyc(); mem_resp_valid = 1'b1; look();
      cyc(); mem_resp_valid = 1'b0; look();
      chk("t6_d_done", 64'(cpu_done), 64'd1);
      cyc(); idle(); look();
      chk("t6_idle_valid", 64'(mem_req_valid), 64'd0);
      cyc(); mem_req_ready = 1'b0; look();
      chk("t6_accepts", 64'(n_acc - acc0), 64'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
